// File: rtl/axi4s_pkg.sv
// Shared definitions for the axi4s AXI4-to-native bridge: burst/response codes,
// FSM state encoding and the WRAP length legality check.
package axi4s_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] BURST_RSVD  = 2'b11;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WDATA = 3'd1,
    ST_WRESP = 3'd2,
    ST_RREQ  = 3'd3,
    ST_RWAIT = 3'd4,
    ST_RDATA = 3'd5
  } state_t;

  // WRAP bursts are only legal with 2, 4, 8 or 16 beats.
  function automatic logic wrap_len_bad(input logic [1:0] burst, input logic [7:0] len);
    return (burst == BURST_WRAP) &&
           !((len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15));
  endfunction

endpackage

// File: rtl/axi4s_burst_addr.sv
// Next-beat address for FIXED/INCR/WRAP bursts, plus WRAP length legality.
// Purely combinational; address arithmetic stays within ADDR_W bits.
module axi4s_burst_addr
  import axi4s_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [2:0]        size,
  input  logic [7:0]        len,
  input  logic [1:0]        burst,
  output logic [ADDR_W-1:0] next_addr,
  output logic              wrap_err
);

  logic [ADDR_W-1:0] step;
  logic [ADDR_W-1:0] incr_addr;
  logic [ADDR_W-1:0] wrap_bytes;
  logic [ADDR_W-1:0] wrap_mask;

  assign step       = ADDR_W'(1) << size;
  assign incr_addr  = addr + step;
  // Wrap window is the whole burst footprint, aligned to its own size.
  assign wrap_bytes = (ADDR_W'(len) + ADDR_W'(1)) << size;
  assign wrap_mask  = wrap_bytes - ADDR_W'(1);
  assign wrap_err   = wrap_len_bad(burst, len);

  always_comb begin
    next_addr = addr;
    case (burst)
      BURST_FIXED: next_addr = addr;
      BURST_INCR:  next_addr = incr_addr;
      BURST_WRAP:  next_addr = (addr & ~wrap_mask) | (incr_addr & wrap_mask);
      default:     next_addr = addr;
    endcase
  end

endmodule

// File: rtl/axi4s.sv
// AXI4 slave front end: one AXI burst at a time, split into single-word native
// val/rdy requests with an in-order read-return strobe.
module axi4s
  import axi4s_pkg::*;
#(
  parameter int AXI_ADDR_W = 32,
  parameter int AXI_DATA_W = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [AXI_ADDR_W-1:0]   s_axi_awaddr,
  input  logic [7:0]              s_axi_awlen,
  input  logic [2:0]              s_axi_awsize,
  input  logic [1:0]              s_axi_awburst,
  input  logic                    s_axi_awlock,
  input  logic [3:0]              s_axi_awcache,
  input  logic [2:0]              s_axi_awprot,
  input  logic [3:0]              s_axi_awqos,
  input  logic                    s_axi_awvalid,
  output logic                    s_axi_awready,
  input  logic [AXI_DATA_W-1:0]   s_axi_wdata,
  input  logic [AXI_DATA_W/8-1:0] s_axi_wstrb,
  input  logic                    s_axi_wlast,
  input  logic                    s_axi_wvalid,
  output logic                    s_axi_wready,
  output logic [1:0]              s_axi_bresp,
  output logic                    s_axi_bvalid,
  input  logic                    s_axi_bready,
  input  logic [AXI_ADDR_W-1:0]   s_axi_araddr,
  input  logic [7:0]              s_axi_arlen,
  input  logic [2:0]              s_axi_arsize,
  input  logic [1:0]              s_axi_arburst,
  input  logic                    s_axi_arlock,
  input  logic [3:0]              s_axi_arcache,
  input  logic [2:0]              s_axi_arprot,
  input  logic [3:0]              s_axi_arqos,
  input  logic                    s_axi_arvalid,
  output logic                    s_axi_arready,
  output logic [AXI_DATA_W-1:0]   s_axi_rdata,
  output logic [1:0]              s_axi_rresp,
  output logic                    s_axi_rlast,
  output logic                    s_axi_rvalid,
  input  logic                    s_axi_rready,
  output logic                    mem_val,
  input  logic                    mem_rdy,
  output logic [AXI_ADDR_W-1:0]   mem_adr,
  output logic [AXI_DATA_W/8-1:0] mem_wen,
  output logic [AXI_DATA_W-1:0]   mem_wdat,
  input  logic                    mem_rvld,
  input  logic [AXI_DATA_W-1:0]   mem_rdat
);

  localparam int SIZE_MAX = $clog2(AXI_DATA_W / 8);

  state_t                  state_reg, state_next;
  logic [AXI_ADDR_W-1:0]   addr_reg, addr_next;
  logic [7:0]              len_reg, len_next;
  logic [2:0]              size_reg, size_next;
  logic [1:0]              burst_reg, burst_next;
  logic [7:0]              cnt_reg, cnt_next;
  logic                    err_reg, err_next;
  logic                    prio_wr_reg, prio_wr_next;
  logic [AXI_DATA_W-1:0]   rdata_reg, rdata_next;

  logic                    aw_grant, ar_grant;
  logic [AXI_ADDR_W-1:0]   sel_addr, nxt_addr;
  logic [7:0]              sel_len;
  logic [2:0]              sel_size;
  logic [1:0]              sel_burst;
  logic                    wrap_err, accept_err, last_beat;
  logic                    unused_sink;

  assign unused_sink = ^{s_axi_awlock, s_axi_awcache, s_axi_awprot, s_axi_awqos,
                         s_axi_arlock, s_axi_arcache, s_axi_arprot, s_axi_arqos};

  assign aw_grant  = s_axi_awvalid && (!s_axi_arvalid || prio_wr_reg);
  assign ar_grant  = s_axi_arvalid && !aw_grant;
  assign last_beat = (cnt_reg == len_reg);

  // The burst helper sees the incoming request while idle (for the accept-time
  // checks) and the latched burst otherwise (for address advance).
  always_comb begin
    sel_addr  = addr_reg;
    sel_len   = len_reg;
    sel_size  = size_reg;
    sel_burst = burst_reg;
    if (state_reg == ST_IDLE) begin
      sel_addr  = aw_grant ? s_axi_awaddr  : s_axi_araddr;
      sel_len   = aw_grant ? s_axi_awlen   : s_axi_arlen;
      sel_size  = aw_grant ? s_axi_awsize  : s_axi_arsize;
      sel_burst = aw_grant ? s_axi_awburst : s_axi_arburst;
    end
  end

  axi4s_burst_addr #(.ADDR_W(AXI_ADDR_W)) u_burst_addr (
    .addr      (sel_addr),
    .size      (sel_size),
    .len       (sel_len),
    .burst     (sel_burst),
    .next_addr (nxt_addr),
    .wrap_err  (wrap_err)
  );

  assign accept_err = (sel_size > 3'(SIZE_MAX)) || (sel_burst == BURST_RSVD) || wrap_err;

  always_comb begin
    state_next    = state_reg;
    addr_next     = addr_reg;
    len_next      = len_reg;
    size_next     = size_reg;
    burst_next    = burst_reg;
    cnt_next      = cnt_reg;
    err_next      = err_reg;
    prio_wr_next  = prio_wr_reg;
    rdata_next    = rdata_reg;
    s_axi_awready = 1'b0;
    s_axi_arready = 1'b0;
    s_axi_wready  = 1'b0;
    s_axi_bvalid  = 1'b0;
    s_axi_bresp   = RESP_OKAY;
    s_axi_rvalid  = 1'b0;
    s_axi_rresp   = RESP_OKAY;
    s_axi_rdata   = '0;
    s_axi_rlast   = 1'b0;
    mem_val       = 1'b0;
    mem_adr       = addr_reg;
    mem_wen       = '0;
    mem_wdat      = '0;

    case (state_reg)
      ST_IDLE: begin
        s_axi_awready = aw_grant;
        s_axi_arready = ar_grant;
        if (aw_grant || ar_grant) begin
          addr_next    = sel_addr;
          len_next     = sel_len;
          size_next    = sel_size;
          burst_next   = sel_burst;
          cnt_next     = '0;
          err_next     = accept_err;
          prio_wr_next = ar_grant;
          state_next   = aw_grant ? ST_WDATA : ST_RREQ;
        end
      end
      ST_WDATA: begin
        // Errored bursts still drain the W channel, just without native traffic.
        mem_val      = s_axi_wvalid && !err_reg;
        s_axi_wready = err_reg || mem_rdy;
        mem_wen      = s_axi_wstrb;
        mem_wdat     = s_axi_wdata;
        if (s_axi_wvalid && s_axi_wready) begin
          cnt_next  = cnt_reg + 8'd1;
          addr_next = nxt_addr;
          if (s_axi_wlast != last_beat) err_next = 1'b1;
          if (last_beat) state_next = ST_WRESP;
        end
      end
      ST_WRESP: begin
        s_axi_bvalid = 1'b1;
        s_axi_bresp  = err_reg ? RESP_SLVERR : RESP_OKAY;
        if (s_axi_bready) state_next = ST_IDLE;
      end
      ST_RREQ: begin
        mem_val = !err_reg;
        if (err_reg) state_next = ST_RDATA;
        else if (mem_rdy) state_next = ST_RWAIT;
      end
      ST_RWAIT: begin
        if (mem_rvld) begin
          rdata_next = mem_rdat;
          state_next = ST_RDATA;
        end
      end
      ST_RDATA: begin
        s_axi_rvalid = 1'b1;
        s_axi_rresp  = err_reg ? RESP_SLVERR : RESP_OKAY;
        s_axi_rdata  = err_reg ? '0 : rdata_reg;
        s_axi_rlast  = last_beat;
        if (s_axi_rready) begin
          if (last_beat) begin
            state_next = ST_IDLE;
          end else begin
            cnt_next   = cnt_reg + 8'd1;
            addr_next  = nxt_addr;
            state_next = ST_RREQ;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= ST_IDLE;
      addr_reg    <= '0;
      len_reg     <= '0;
      size_reg    <= '0;
      burst_reg   <= '0;
      cnt_reg     <= '0;
      err_reg     <= 1'b0;
      prio_wr_reg <= 1'b1;
      rdata_reg   <= '0;
    end else begin
      state_reg   <= state_next;
      addr_reg    <= addr_next;
      len_reg     <= len_next;
      size_reg    <= size_next;
      burst_reg   <= burst_next;
      cnt_reg     <= cnt_next;
      err_reg     <= err_next;
      prio_wr_reg <= prio_wr_next;
      rdata_reg   <= rdata_next;
    end
  end

endmodule

// File: tb/tb_axi4s.sv
// Directed self-checking bench for axi4s: a simple native memory model returns
// the request address as read data and logs writes.
module tb_axi4s;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] s_axi_awaddr;
  logic [7:0]  s_axi_awlen;
  logic [2:0]  s_axi_awsize;
  logic [1:0]  s_axi_awburst;
  logic        s_axi_awlock = 1'b0;
  logic [3:0]  s_axi_awcache = 4'h0;
  logic [2:0]  s_axi_awprot = 3'h0;
  logic [3:0]  s_axi_awqos = 4'h0;
  logic        s_axi_awvalid, s_axi_awready;
  logic [31:0] s_axi_wdata;
  logic [3:0]  s_axi_wstrb;
  logic        s_axi_wlast, s_axi_wvalid, s_axi_wready;
  logic [1:0]  s_axi_bresp;
  logic        s_axi_bvalid, s_axi_bready;
  logic [31:0] s_axi_araddr;
  logic [7:0]  s_axi_arlen;
  logic [2:0]  s_axi_arsize;
  logic [1:0]  s_axi_arburst;
  logic        s_axi_arlock = 1'b0;
  logic [3:0]  s_axi_arcache = 4'h0;
  logic [2:0]  s_axi_arprot = 3'h0;
  logic [3:0]  s_axi_arqos = 4'h0;
  logic        s_axi_arvalid, s_axi_arready;
  logic [31:0] s_axi_rdata;
  logic [1:0]  s_axi_rresp;
  logic        s_axi_rlast, s_axi_rvalid, s_axi_rready;
  logic        mem_val, mem_rdy;
  logic [31:0] mem_adr;
  logic [3:0]  mem_wen;
  logic [31:0] mem_wdat;
  logic        mem_rvld = 1'b0;
  logic [31:0] mem_rdat = 32'h0;

  int          n_cmp = 0;
  int          n_err = 0;
  int          wr_cnt = 0;
  int          mem_val_cyc = 0;
  logic [31:0] wr_adr_last = 32'h0;
  logic [31:0] wr_dat_last = 32'h0;
  logic [3:0]  wr_wen_last = 4'h0;

  always #5 clk = ~clk;

  axi4s #(.AXI_ADDR_W(32), .AXI_DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen), .s_axi_awsize(s_axi_awsize),
    .s_axi_awburst(s_axi_awburst), .s_axi_awlock(s_axi_awlock), .s_axi_awcache(s_axi_awcache),
    .s_axi_awprot(s_axi_awprot), .s_axi_awqos(s_axi_awqos), .s_axi_awvalid(s_axi_awvalid),
    .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
    .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen), .s_axi_arsize(s_axi_arsize),
    .s_axi_arburst(s_axi_arburst), .s_axi_arlock(s_axi_arlock), .s_axi_arcache(s_axi_arcache),
    .s_axi_arprot(s_axi_arprot), .s_axi_arqos(s_axi_arqos), .s_axi_arvalid(s_axi_arvalid),
    .s_axi_arready(s_axi_arready),
    .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp), .s_axi_rlast(s_axi_rlast),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .mem_val(mem_val), .mem_rdy(mem_rdy), .mem_adr(mem_adr), .mem_wen(mem_wen),
    .mem_wdat(mem_wdat), .mem_rvld(mem_rvld), .mem_rdat(mem_rdat)
  );

  // Native memory: read data = request address, returned one cycle after acceptance.
  always @(posedge clk) begin
    mem_rvld <= 1'b0;
    if (mem_val) mem_val_cyc <= mem_val_cyc + 1;
    if (mem_val && mem_rdy) begin
      if (mem_wen == 4'h0) begin
        mem_rvld <= 1'b1;
        mem_rdat <= mem_adr;
      end else begin
        wr_cnt      <= wr_cnt + 1;
        wr_adr_last <= mem_adr;
        wr_dat_last <= mem_wdat;
        wr_wen_last <= mem_wen;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
    $display("chk %-14s obs=0x%0h exp=0x%0h", tag, obs, exp);
  endtask

  task automatic drive_aw(input logic [31:0] a, input logic [7:0] l, input logic [2:0] s,
                          input logic [1:0] b);
    s_axi_awaddr = a; s_axi_awlen = l; s_axi_awsize = s; s_axi_awburst = b;
    s_axi_awvalid = 1'b1;
  endtask

  task automatic drive_ar(input logic [31:0] a, input logic [7:0] l, input logic [2:0] s,
                          input logic [1:0] b);
    s_axi_araddr = a; s_axi_arlen = l; s_axi_arsize = s; s_axi_arburst = b;
    s_axi_arvalid = 1'b1;
  endtask

  task automatic wait_aw_hs();
    int n = 0;
    #1;
    while (!s_axi_awready && n < 100) begin @(negedge clk); #1; n++; end
    chk("aw_handshake", {31'b0, s_axi_awready}, 32'h1);
    @(negedge clk);
    s_axi_awvalid = 1'b0;
  endtask

  task automatic wait_ar_hs();
    int n = 0;
    #1;
    while (!s_axi_arready && n < 100) begin @(negedge clk); #1; n++; end
    chk("ar_handshake", {31'b0, s_axi_arready}, 32'h1);
    @(negedge clk);
    s_axi_arvalid = 1'b0;
  endtask

  task automatic send_w(input logic [31:0] d, input logic [3:0] st, input logic last);
    int n = 0;
    s_axi_wdata = d; s_axi_wstrb = st; s_axi_wlast = last; s_axi_wvalid = 1'b1;
    #1;
    while (!s_axi_wready && n < 100) begin @(negedge clk); #1; n++; end
    chk("w_handshake", {31'b0, s_axi_wready}, 32'h1);
    @(negedge clk);
    s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0;
  endtask

  task automatic get_b(input logic [1:0] exp_resp);
    int n = 0;
    s_axi_bready = 1'b1;
    #1;
    while (!s_axi_bvalid && n < 100) begin @(negedge clk); #1; n++; end
    chk("bvalid", {31'b0, s_axi_bvalid}, 32'h1);
    chk("bresp", {30'b0, s_axi_bresp}, {30'b0, exp_resp});
    @(negedge clk);
    s_axi_bready = 1'b0;
  endtask

  task automatic get_r(input logic [31:0] exp_data, input logic exp_last, input logic [1:0] exp_resp);
    int n = 0;
    s_axi_rready = 1'b1;
    #1;
    while (!s_axi_rvalid && n < 100) begin @(negedge clk); #1; n++; end
    chk("rvalid", {31'b0, s_axi_rvalid}, 32'h1);
    chk("rdata", s_axi_rdata, exp_data);
    chk("rlast", {31'b0, s_axi_rlast}, {31'b0, exp_last});
    chk("rresp", {30'b0, s_axi_rresp}, {30'b0, exp_resp});
    @(negedge clk);
    s_axi_rready = 1'b0;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk(tag, {25'b0, s_axi_awready, s_axi_arready, s_axi_wready, s_axi_bvalid,
              s_axi_rvalid, s_axi_rlast, mem_val}, 32'h0);
    chk("idle_rdata", s_axi_rdata, 32'h0);
    chk("idle_resp", {28'b0, s_axi_bresp, s_axi_rresp}, 32'h0);
    chk("idle_mem", {mem_adr[27:0], mem_wen} | mem_wdat, 32'h0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int v0;
    int w0;
    rst_n = 1'b0;
    s_axi_awaddr = '0; s_axi_awlen = '0; s_axi_awsize = '0; s_axi_awburst = '0; s_axi_awvalid = 1'b0;
    s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wlast = 1'b0; s_axi_wvalid = 1'b0;
    s_axi_bready = 1'b0;
    s_axi_araddr = '0; s_axi_arlen = '0; s_axi_arsize = '0; s_axi_arburst = '0; s_axi_arvalid = 1'b0;
    s_axi_rready = 1'b0;
    mem_rdy = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    chk_idle_outputs("reset_outs");
    @(negedge clk);
    rst_n = 1'b1;

    // Single write, native request contents checked while presented
    drive_aw(32'h100, 8'd0, 3'd2, 2'b01);
    wait_aw_hs();
    s_axi_wdata = 32'hDEADBEEF; s_axi_wstrb = 4'hF; s_axi_wlast = 1'b1; s_axi_wvalid = 1'b1;
    #1;
    chk("wr_mem_val", {31'b0, mem_val}, 32'h1);
    chk("wr_mem_adr", mem_adr, 32'h100);
    chk("wr_mem_wen", {28'b0, mem_wen}, 32'hF);
    chk("wr_mem_wdat", mem_wdat, 32'hDEADBEEF);
    send_w(32'hDEADBEEF, 4'hF, 1'b1);
    get_b(2'b00);
    chk("wr_count", wr_cnt, 32'd1);
    chk("wr_log_adr", wr_adr_last, 32'h100);
    chk("wr_log_dat", wr_dat_last, 32'hDEADBEEF);
    chk("wr_log_wen", {28'b0, wr_wen_last}, 32'hF);

    // INCR read, 4 beats
    drive_ar(32'h200, 8'd3, 3'd2, 2'b01);
    wait_ar_hs();
    get_r(32'h200, 1'b0, 2'b00);
    get_r(32'h204, 1'b0, 2'b00);
    get_r(32'h208, 1'b0, 2'b00);
    get_r(32'h20C, 1'b1, 2'b00);

    // WRAP read, wraps at the 16-byte boundary
    drive_ar(32'h108, 8'd3, 3'd2, 2'b10);
    wait_ar_hs();
    get_r(32'h108, 1'b0, 2'b00);
    get_r(32'h10C, 1'b0, 2'b00);
    get_r(32'h100, 1'b0, 2'b00);
    get_r(32'h104, 1'b1, 2'b00);

    // Arbitration from reset: write first, read next, then priority alternates
    do_reset();
    drive_aw(32'h300, 8'd0, 3'd2, 2'b01);
    drive_ar(32'h400, 8'd0, 3'd2, 2'b01);
    #1;
    chk("arb_aw_first", {31'b0, s_axi_awready}, 32'h1);
    chk("arb_ar_held", {31'b0, s_axi_arready}, 32'h0);
    wait_aw_hs();
    send_w(32'h11112222, 4'hF, 1'b1);
    drive_aw(32'h304, 8'd0, 3'd2, 2'b01);
    get_b(2'b00);
    #1;
    chk("arb_ar_next", {31'b0, s_axi_arready}, 32'h1);
    chk("arb_aw_wait", {31'b0, s_axi_awready}, 32'h0);
    wait_ar_hs();
    get_r(32'h400, 1'b1, 2'b00);
    wait_aw_hs();
    send_w(32'h33334444, 4'h3, 1'b1);
    get_b(2'b00);
    chk("arb_wr2_adr", wr_adr_last, 32'h304);
    chk("arb_wr2_wen", {28'b0, wr_wen_last}, 32'h3);

    // Write len1 with early wlast: both beats consumed, only first reaches memory
    w0 = wr_cnt;
    drive_aw(32'h800, 8'd1, 3'd2, 2'b01);
    wait_aw_hs();
    send_w(32'hAAAA0000, 4'hF, 1'b1);
    send_w(32'hBBBB0000, 4'hF, 1'b0);
    get_b(2'b10);
    chk("wlast_err_wrs", wr_cnt - w0, 32'd1);

    // Oversized awsize: no native traffic, SLVERR
    v0 = mem_val_cyc;
    drive_aw(32'h900, 8'd0, 3'd3, 2'b01);
    wait_aw_hs();
    send_w(32'hCCCC0000, 4'hF, 1'b1);
    get_b(2'b10);
    chk("size_err_noval", mem_val_cyc - v0, 32'd0);

    // Illegal WRAP length: SLVERR beats with zero data, no native traffic
    v0 = mem_val_cyc;
    drive_ar(32'h100, 8'd2, 3'd2, 2'b10);
    wait_ar_hs();
    get_r(32'h0, 1'b0, 2'b10);
    get_r(32'h0, 1'b0, 2'b10);
    get_r(32'h0, 1'b1, 2'b10);
    chk("wrap_err_noval", mem_val_cyc - v0, 32'd0);

    // Back-pressure: mem_rdy low then rready low, outputs held stable
    drive_ar(32'h500, 8'd1, 3'd2, 2'b01);
    mem_rdy = 1'b0;
    wait_ar_hs();
    k = $urandom_range(2, 5);
    for (int i = 0; i < k; i++) begin
      #1;
      chk("stall_mem_val", {31'b0, mem_val}, 32'h1);
      chk("stall_mem_adr", mem_adr, 32'h500);
      @(negedge clk);
    end
    mem_rdy = 1'b1;
    v0 = 0;
    #1;
    while (!s_axi_rvalid && v0 < 100) begin @(negedge clk); #1; v0++; end
    k = $urandom_range(2, 5);
    for (int i = 0; i < k; i++) begin
      chk("stall_rdata", s_axi_rdata, 32'h500);
      chk("stall_rlast", {31'b0, s_axi_rlast}, 32'h0);
      @(negedge clk);
      #1;
    end
    get_r(32'h500, 1'b0, 2'b00);
    get_r(32'h504, 1'b1, 2'b00);

    // Reset pulse in the middle of a write burst
    drive_aw(32'h600, 8'd3, 3'd2, 2'b01);
    wait_aw_hs();
    send_w(32'h00000001, 4'hF, 1'b0);
    s_axi_wdata = 32'h2; s_axi_wstrb = 4'hF; s_axi_wvalid = 1'b1;
    rst_n = 1'b0;
    #1;
    chk_idle_outputs("midburst_rst");
    s_axi_wvalid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    drive_ar(32'h700, 8'd0, 3'd2, 2'b01);
    wait_ar_hs();
    get_r(32'h700, 1'b1, 2'b00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
